// File: rtl/bar_responder.sv
// Responder end of a single-outstanding request/response channel backed by a
// DEPTH x DW register array, answering each request after LATENCY cycles.
module bar_responder #(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   AW      = 4,
  parameter int unsigned   LATENCY = 2,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          busy
);

  localparam int unsigned DEPTH    = 2 ** AW;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          // Writes commit on the accept edge; reads snapshot the array on the same edge.
          if (req_write) begin
            mem_d[req_addr] = req_wdata;
            rdata_d         = '0;
          end else begin
            rdata_d = mem_q[req_addr];
          end
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_VAL;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = 1'b0;

endmodule

// File: tb/tb_bar_responder.sv
// Directed bench: LATENCY=2 responder driven from a vector table plus
// multi-cycle sequences, and a LATENCY=1 instance for back-to-back timing.
module tb_bar_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, resp_ready;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        rv1, rw1, sr1;
  logic [3:0]  ra1;
  logic [31:0] rwd1;
  logic        rr1, sv1, re1, b1;
  logic [31:0] rd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bar_responder #(.DW(32), .AW(4), .LATENCY(2), .RST_VAL(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  bar_responder #(.DW(32), .AW(4), .LATENCY(1), .RST_VAL(32'hA5A5_0000)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv1), .req_ready(rr1), .req_write(rw1),
    .req_addr(ra1), .req_wdata(rwd1),
    .resp_valid(sv1), .resp_ready(sr1), .resp_rdata(rd1),
    .resp_err(re1), .busy(b1)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the handshake.
  task automatic txn(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp, input string tag);
    int n;
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 32'd2);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"}, {31'b0, resp_err}, 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_vld_drop"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 4'd3,  32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 4'd3,  32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 4'd0,  32'h0000_0001, 32'h0};
    vecs[3] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 32'h0};
    vecs[4] = '{1'b0, 4'd0,  32'h0,         32'h0000_0001};
    vecs[5] = '{1'b0, 4'd15, 32'h0,         32'hFFFF_FFFF};
    vecs[6] = '{1'b0, 4'd7,  32'h0,         32'h0};
    vecs[7] = '{1'b1, 4'd3,  32'h1234_5678, 32'h0};

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
    rv1 = 1'b0; rw1 = 1'b0; ra1 = '0; rwd1 = '0; sr1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T2 and table
    for (int i = 0; i < 8; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
    end
    txn(1'b0, 4'd3, 32'h0, 32'h1234_5678, "rd3_new");

    // T3 backpressure
    txn(1'b1, 4'd5, 32'hABCD_1234, 32'h0, "wr5");
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", n, 32'd2);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid%0d", c), {31'b0, resp_valid}, 32'd1);
      chk($sformatf("bp_rdata%0d", c), resp_rdata, 32'hABCD_1234);
      chk($sformatf("bp_ready%0d", c), {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_drop", {31'b0, resp_valid}, 32'd0);

    // T4 request held during WAIT/RESP
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 4'd9; req_wdata = 32'h0000_0055;
    n = 0;
    while (!resp_valid && n < 20) begin
      chk("t4_blocked", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("t4_lat", n, 32'd2);
    chk("t4_rdata", resp_rdata, 32'h1234_5678);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("t4_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("t4_idle_valid", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t4_accept_busy", {31'b0, busy}, 32'd1);
    chk("t4_accept_ready", {31'b0, req_ready}, 32'd0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_lat2", n, 32'd2);
    chk("t4_wr_rdata", resp_rdata, 32'h0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    txn(1'b0, 4'd9, 32'h0, 32'h0000_0055, "t4_rd9");

    // T1 reset mid-RESP
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t1_in_resp", {31'b0, resp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_async_valid", {31'b0, resp_valid}, 32'd0);
    chk("t1_async_ready", {31'b0, req_ready}, 32'd1);
    chk("t1_async_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1_no_resp", {31'b0, resp_valid}, 32'd0);
    txn(1'b0, 4'd3, 32'h0, 32'h0, "t1_rd3");
    txn(1'b0, 4'd9, 32'h0, 32'h0, "t1_rd9");

    // T5 LATENCY=1 back-to-back reads
    sr1 = 1'b1; rv1 = 1'b1; rw1 = 1'b0; ra1 = 4'd0;
    chk("t5_ready0", {31'b0, rr1}, 32'd1);
    @(posedge clk); #1;
    ra1 = 4'd15;
    chk("t5_wait_valid", {31'b0, sv1}, 32'd0);
    chk("t5_wait_ready", {31'b0, rr1}, 32'd0);
    @(posedge clk); #1;
    chk("t5_resp0_valid", {31'b0, sv1}, 32'd1);
    chk("t5_resp0_rdata", rd1, 32'hA5A5_0000);
    chk("t5_resp0_ready", {31'b0, rr1}, 32'd0);
    @(posedge clk); #1;
    chk("t5_idle_valid", {31'b0, sv1}, 32'd0);
    chk("t5_idle_ready", {31'b0, rr1}, 32'd1);
    @(posedge clk); #1;
    rv1 = 1'b0;
    chk("t5_acc2_busy", {31'b0, b1}, 32'd1);
    chk("t5_acc2_valid", {31'b0, sv1}, 32'd0);
    @(posedge clk); #1;
    chk("t5_resp1_valid", {31'b0, sv1}, 32'd1);
    chk("t5_resp1_rdata", rd1, 32'hA5A5_0000);
    chk("t5_resp1_err", {31'b0, re1}, 32'd0);
    @(posedge clk); #1;
    sr1 = 1'b0;
    chk("t5_done", {31'b0, sv1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
